// File: rtl/stage_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : stage_sequencer
//  Description : Multi-cycle instruction stage sequencer sitting directly
//                upstream of main_control. Walks each instruction through a
//                per-opcode path of FETCH/DECODE/EXECUTE/MEM/WB stages, stalls
//                on memory, pulses retire/illegal strobes and counts retired
//                instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module stage_sequencer #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic [2:0]       stage,
  output logic             ir_write,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  // Stage encoding is exactly the code main_control decodes, so the state
  // register drives the 'stage' bus directly with no output decode.
  typedef enum logic [2:0] {
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_EXECUTE = 3'b011,
    ST_MEM     = 3'b100,
    ST_WB      = 3'b101
  } stage_t;

  // Instruction classes; each class owns a fixed stage path.
  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_PUSH    = 3'd5,
    CL_POP     = 3'd6,
    CL_ILLEGAL = 3'd7
  } class_t;

  stage_t           state_q;
  stage_t           state_d;
  class_t           class_q;
  class_t           class_d;
  class_t           dec_class;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] count_q;

  // Opcode classifier; only consulted while in DECODE.
  always_comb begin
    dec_class = CL_ILLEGAL;
    if (op <= OP_W'(4)) begin
      dec_class = CL_ALU;
    end else if (op <= OP_W'(6)) begin
      dec_class = CL_LOAD;
    end else if (op == OP_W'(7)) begin
      dec_class = CL_STORE;
    end else if (op <= OP_W'(11)) begin
      dec_class = CL_BRANCH;
    end else if (op <= OP_W'(14)) begin
      dec_class = CL_JUMP;
    end else if (op == OP_W'(15)) begin
      dec_class = CL_PUSH;
    end else if (op == OP_W'(16)) begin
      dec_class = CL_POP;
    end
  end

  // Next-stage selection plus retire/illegal events for the coming edge.
  // EXECUTE and MEM steer only from the class latched in DECODE, so the op
  // bus is free to change once DECODE is over.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    retire  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        class_d = dec_class;
        case (dec_class)
          CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_PUSH, CL_POP: begin
            state_d = ST_EXECUTE;
          end
          CL_JUMP: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default: begin
            state_d = ST_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      ST_EXECUTE: begin
        case (class_q)
          CL_LOAD, CL_STORE, CL_PUSH, CL_POP: begin
            state_d = ST_MEM;
          end
          CL_ALU: begin
            state_d = ST_WB;
          end
          CL_BRANCH: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          // JUMP/ILLEGAL never reach EXECUTE; recover without retiring.
          default: begin
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          case (class_q)
            CL_LOAD, CL_POP: begin
              state_d = ST_WB;
            end
            CL_STORE, CL_PUSH: begin
              state_d = ST_FETCH;
              retire  = 1'b1;
            end
            default: begin
              state_d = ST_FETCH;
            end
          endcase
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      // Unused codes 000/110/111 fall back to FETCH.
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Stage and class registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      class_q <= CL_ALU;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  // Registered strobes and the wrapping retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
      count_q    <= '0;
    end else begin
      instr_done <= retire;
      illegal_op <= illegal;
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign stage       = state_q;
  assign ir_write    = (state_q == ST_FETCH) && mem_ready;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_stage_sequencer
//  Description : Self-checking bench for stage_sequencer: directed vector
//                table, reset/wrap sequences and randomized traffic against a
//                path-table reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stage_sequencer;

  localparam logic [2:0] S_F = 3'd1;
  localparam logic [2:0] S_D = 3'd2;
  localparam logic [2:0] S_E = 3'd3;
  localparam logic [2:0] S_M = 3'd4;
  localparam logic [2:0] S_W = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic        mem_ready;
  logic [2:0]  stage;
  logic        ir_write;
  logic        instr_done;
  logic        illegal_op;
  logic [15:0] instr_count;
  logic [2:0]  s_stage;
  logic        s_ir_write;
  logic        s_instr_done;
  logic        s_illegal_op;
  logic [7:0]  s_instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  stage_sequencer #(.OP_W(6), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .stage(stage), .ir_write(ir_write), .instr_done(instr_done),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  // Narrow-counter instance sharing all stimulus, used to observe wrap cheaply.
  stage_sequencer #(.OP_W(6), .CNT_W(8)) dut_small (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .stage(s_stage), .ir_write(s_ir_write), .instr_done(s_instr_done),
    .illegal_op(s_illegal_op), .instr_count(s_instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [2:0]  st;
    logic        irw;
    logic        done;
    logic        ill;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] o, input logic mr, input logic [2:0] st,
                     input logic irw, input logic done, input logic ill, input logic [15:0] cnt);
    vec_t v;
    v.op = o; v.mr = mr; v.st = st; v.irw = irw; v.done = done; v.ill = ill; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [2:0]  m_stage;
  logic        m_done;
  logic        m_ill;
  logic [15:0] m_cnt;
  logic [2:0]  m_path[$];

  // Stages remaining after DECODE for an opcode; empty path = retire at DECODE.
  task automatic load_path(input logic [5:0] o, output bit ill);
    m_path.delete();
    ill = 1'b0;
    if (o <= 6'd4) begin
      m_path.push_back(S_E); m_path.push_back(S_W);
    end else if (o <= 6'd6) begin
      m_path.push_back(S_E); m_path.push_back(S_M); m_path.push_back(S_W);
    end else if (o == 6'd7) begin
      m_path.push_back(S_E); m_path.push_back(S_M);
    end else if (o <= 6'd11) begin
      m_path.push_back(S_E);
    end else if (o <= 6'd14) begin
      // jump: nothing after DECODE
    end else if (o == 6'd15) begin
      m_path.push_back(S_E); m_path.push_back(S_M);
    end else if (o == 6'd16) begin
      m_path.push_back(S_E); m_path.push_back(S_M); m_path.push_back(S_W);
    end else begin
      ill = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_stage = S_F; m_done = 1'b0; m_ill = 1'b0; m_cnt = 16'd0;
    m_path.delete();
  endtask

  task automatic model_step(input logic [5:0] o, input logic mr);
    bit ill;
    bit adv;
    m_done = 1'b0;
    m_ill  = 1'b0;
    adv    = 1'b0;
    ill    = 1'b0;
    if (m_stage == S_F) begin
      if (mr) m_stage = S_D;
    end else if (m_stage == S_D) begin
      load_path(o, ill);
      if (ill) begin
        m_stage = S_F;
        m_ill   = 1'b1;
      end else begin
        adv = 1'b1;
      end
    end else if (m_stage == S_M) begin
      adv = mr;
    end else begin
      adv = 1'b1;
    end
    if (adv) begin
      if (m_path.size() == 0) begin
        m_stage = S_F;
        m_done  = 1'b1;
        m_cnt   = m_cnt + 16'd1;
      end else begin
        m_stage = m_path.pop_front();
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " stage"}, stage, m_stage);
    chk({tag, " instr_done"}, instr_done, m_done);
    chk({tag, " illegal_op"}, illegal_op, m_ill);
    chk({tag, " instr_count"}, instr_count, m_cnt);
    chk({tag, " ir_write"}, ir_write, (m_stage == S_F) && mem_ready);
    chk({tag, " small_count"}, s_instr_count, m_cnt[7:0]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("reset stage", stage, S_F);
    chk("reset count", instr_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    op = 6'd0;
    mem_ready = 1'b0;
    #1;
    chk("por stage", stage, S_F);
    chk("por instr_done", instr_done, 1'b0);
    chk("por illegal_op", illegal_op, 1'b0);
    chk("por count", instr_count, 16'd0);

    // op, mr, stage, ir_write, done, illegal, count
    add(6'h00, 1, S_F, 1, 0, 0, 0);  // ADD
    add(6'h01, 1, S_D, 0, 0, 0, 0);
    add(6'h3F, 0, S_E, 0, 0, 0, 0);
    add(6'h05, 0, S_W, 0, 0, 0, 0);
    add(6'h00, 1, S_F, 1, 1, 0, 1);  // LW with 3 memory waits
    add(6'h05, 1, S_D, 0, 0, 0, 1);
    add(6'h00, 1, S_E, 0, 0, 0, 1);
    add(6'h3F, 0, S_M, 0, 0, 0, 1);
    add(6'h0C, 0, S_M, 0, 0, 0, 1);
    add(6'h00, 0, S_M, 0, 0, 0, 1);
    add(6'h00, 1, S_M, 0, 0, 0, 1);
    add(6'h00, 0, S_W, 0, 0, 0, 1);
    add(6'h00, 1, S_F, 1, 1, 0, 2);  // illegal 111111
    add(6'h3F, 1, S_D, 0, 0, 0, 2);
    add(6'h00, 1, S_F, 1, 0, 1, 2);  // BEQ
    add(6'h0A, 1, S_D, 0, 0, 0, 2);
    add(6'h3F, 1, S_E, 0, 0, 0, 2);
    add(6'h00, 1, S_F, 1, 1, 0, 3);  // SW
    add(6'h07, 1, S_D, 0, 0, 0, 3);
    add(6'h10, 0, S_E, 0, 0, 0, 3);
    add(6'h00, 1, S_M, 0, 0, 0, 3);
    add(6'h00, 1, S_F, 1, 1, 0, 4);  // PUSH
    add(6'h0F, 1, S_D, 0, 0, 0, 4);
    add(6'h05, 1, S_E, 0, 0, 0, 4);
    add(6'h00, 1, S_M, 0, 0, 0, 4);
    add(6'h00, 0, S_F, 0, 1, 0, 5);  // fetch stall
    add(6'h00, 1, S_F, 1, 0, 0, 5);  // JUMP
    add(6'h0C, 0, S_D, 0, 0, 0, 5);
    add(6'h00, 1, S_F, 1, 1, 0, 6);  // POP
    add(6'h10, 0, S_D, 0, 0, 0, 6);
    add(6'h00, 0, S_E, 0, 0, 0, 6);
    add(6'h00, 1, S_M, 0, 0, 0, 6);
    add(6'h00, 0, S_W, 0, 0, 0, 6);
    add(6'h00, 0, S_F, 0, 1, 0, 7);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      op = vecs[i].op;
      mem_ready = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d stage", i), stage, vecs[i].st);
      chk($sformatf("vec%0d ir_write", i), ir_write, vecs[i].irw);
      chk($sformatf("vec%0d instr_done", i), instr_done, vecs[i].done);
      chk($sformatf("vec%0d illegal_op", i), illegal_op, vecs[i].ill);
      chk($sformatf("vec%0d count", i), instr_count, vecs[i].cnt);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of EXECUTE.
    op = 6'h01;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t1 pre stage", stage, S_E);
    reset = 1'b1;
    #1;
    chk("t1 async stage", stage, S_F);
    chk("t1 async count", instr_count, 16'd0);
    chk("t1 async done", instr_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("t1 release stage", stage, S_F);
    chk("t1 release ir_write", ir_write, 1'b1);
    @(negedge clk);
    #1;
    chk("t1 decode stage", stage, S_D);
    chk("t1 no done", instr_done, 1'b0);

    // Randomized traffic against the path model.
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = 6'($urandom_range(0, 16));
      mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_model($sformatf("rnd%0d", k));
      model_step(op, mem_ready);
      @(negedge clk);
    end

    // Back-to-back JUMPs: 2 cycles each, narrow counter wraps past 255.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      op = 6'h0C;
      mem_ready = 1'b1;
      #1;
      check_model($sformatf("jmp%0d", k));
      model_step(op, mem_ready);
      @(negedge clk);
    end
    #1;
    chk("jump count", instr_count, 16'd300);
    chk("jump small wrap", s_instr_count, 8'd44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
